// File: rtl/power_sequence_arbiter_if.sv
// power_sequence_arbiter_if
// Bundles the request/handshake signals between the power sequence arbiter
// and its environment (request register on one side, switch chains on the
// other).
//   want_on        : requested power state per domain (level)
//   domain_request : drives parent_request of each chain root
//   domain_ready   : chain fully powered (child_ready of last stage)
//   domain_silent  : chain fully off (child_silent of last stage)
//   domain_on      : domain powered and usable
//   busy           : arbiter not idle
//   active_index   : domain currently being sequenced
//   timeout_err    : sticky per-domain watchdog error
//   err_clear      : clears all timeout_err bits
// Modports: master = arbiter side, slave = environment side.
interface power_sequence_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  want_on;
    logic [N-1:0]  domain_request;
    logic [N-1:0]  domain_ready;
    logic [N-1:0]  domain_silent;
    logic [N-1:0]  domain_on;
    logic          busy;
    logic [IW-1:0] active_index;
    logic [N-1:0]  timeout_err;
    logic          err_clear;

    modport master (
        input  want_on, domain_ready, domain_silent, err_clear,
        output domain_request, domain_on, busy, active_index, timeout_err
    );

    modport slave (
        output want_on, domain_ready, domain_silent, err_clear,
        input  domain_request, domain_on, busy, active_index, timeout_err
    );
endinterface

// File: rtl/power_sequence_arbiter.sv
// power_sequence_arbiter
// Serialises power transitions of up to N power-switch chains: one domain
// ramps at a time, pending domains are served round-robin, and a fixed
// settle gap follows every completed transition.
// Ports:
//   clock        : sole clock
//   sync_resetn  : synchronous active-low reset
//   bus (master) : want_on / domain_request / domain_ready / domain_silent /
//                  domain_on / busy / active_index / timeout_err / err_clear
// Optional feature macro: POWER_SEQ_TIMEOUT_EN (per-transition watchdog with
// sticky timeout_err; without it the ramp states wait indefinitely and
// timeout_err is tied 0).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | search pending set from last+1, launch next transition
// RAMP_UP   | request raised, waiting for domain_ready of active domain
// RAMP_DOWN | request dropped, waiting for domain_silent of active domain
// SETTLE    | fixed idle gap before the next transition may start
module power_sequence_arbiter #(
    parameter int N              = 4,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                      clock,
    input logic                      sync_resetn,
    power_sequence_arbiter_if.master bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2,
        SETTLE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  req_q, req_d;
    logic [N-1:0]  on_q, on_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] last_q, last_d;
    logic [7:0]    settle_q, settle_d;

    logic [N-1:0]  err_mask;
    logic [N-1:0]  pending;
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] cand;

`ifdef POWER_SEQ_TIMEOUT_EN
    logic [15:0]   wdog_q, wdog_d;
    logic [N-1:0]  err_q, err_d;
    logic          wdog_hit;

    assign wdog_hit = (wdog_q == 16'(TIMEOUT_CYCLES - 1));
    assign err_mask = err_q;
`else
    logic          unused_err_clear;

    assign unused_err_clear = bus.err_clear;
    assign err_mask         = '0;
`endif

    // A domain is pending while its request level disagrees with want_on;
    // domains holding a watchdog error are parked until cleared.
    assign pending = (bus.want_on ^ req_q) & ~err_mask;

    // Round-robin search starting just after the last served domain.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_q) + k) % N);
            if (!sel_found && pending[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        on_d     = on_q;
        idx_d    = idx_q;
        last_d   = last_q;
        settle_d = settle_q;
`ifdef POWER_SEQ_TIMEOUT_EN
        wdog_d   = wdog_q;
        // A timeout set below in the same cycle overrides this clear.
        err_d    = err_q & ~{N{bus.err_clear}};
`endif
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    idx_d          = sel_idx;
                    last_d         = sel_idx;
                    req_d[sel_idx] = ~req_q[sel_idx];
`ifdef POWER_SEQ_TIMEOUT_EN
                    wdog_d         = '0;
`endif
                    if (req_q[sel_idx]) begin
                        // Domain becomes unusable as soon as teardown starts.
                        on_d[sel_idx] = 1'b0;
                        state_d       = RAMP_DOWN;
                    end else begin
                        state_d       = RAMP_UP;
                    end
                end
            end
            RAMP_UP: begin
`ifdef POWER_SEQ_TIMEOUT_EN
                wdog_d = wdog_q + 16'd1;
`endif
                if (bus.domain_ready[idx_q]) begin
                    on_d[idx_q] = 1'b1;
                    settle_d    = 8'(SETTLE_CYCLES);
                    state_d     = SETTLE;
                end
`ifdef POWER_SEQ_TIMEOUT_EN
                else if (wdog_hit) begin
                    err_d[idx_q] = 1'b1;
                    settle_d     = 8'(SETTLE_CYCLES);
                    state_d      = SETTLE;
                end
`endif
            end
            RAMP_DOWN: begin
`ifdef POWER_SEQ_TIMEOUT_EN
                wdog_d = wdog_q + 16'd1;
`endif
                if (bus.domain_silent[idx_q]) begin
                    settle_d = 8'(SETTLE_CYCLES);
                    state_d  = SETTLE;
                end
`ifdef POWER_SEQ_TIMEOUT_EN
                else if (wdog_hit) begin
                    err_d[idx_q] = 1'b1;
                    settle_d     = 8'(SETTLE_CYCLES);
                    state_d      = SETTLE;
                end
`endif
            end
            SETTLE: begin
                if (settle_q == 8'd1) begin
                    state_d = IDLE;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!sync_resetn) begin
            state_q  <= IDLE;
            req_q    <= '0;
            on_q     <= '0;
            idx_q    <= '0;
            last_q   <= IW'(N - 1);
            settle_q <= '0;
`ifdef POWER_SEQ_TIMEOUT_EN
            wdog_q   <= '0;
            err_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            on_q     <= on_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            settle_q <= settle_d;
`ifdef POWER_SEQ_TIMEOUT_EN
            wdog_q   <= wdog_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.domain_request = req_q;
    assign bus.domain_on      = on_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.active_index   = idx_q;
`ifdef POWER_SEQ_TIMEOUT_EN
    assign bus.timeout_err    = err_q;
`else
    assign bus.timeout_err    = '0;
`endif

endmodule
